// File: rtl/ifetch.sv
// ifetch: RV32I fetch front end with credit-limited request issue, in-order response queue and redirect flush.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to fault on misaligned redirects instead of masking them.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_fault
);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = CW1'(DEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(DEPTH - 1)) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [31:0]   q_pc_q   [DEPTH];
    logic [31:0]   q_data_q [DEPTH];
    logic [31:0]   tag_pc_q [DEPTH];

    logic          run_s, req_fire_s, pop_s, push_s;
    logic [31:0]   redir_pc_s;
    logic [CW:0]   credit_s;

`ifdef IFETCH_ALIGN_CHECK_EN
    typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;
    state_t state_q;
    logic   fault_q;

    // Each redirect decides RUN or FAULT from its alignment; fault flag is the registered view of it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            if (redirect_pc[1:0] != 2'b00) begin
                state_q <= ST_FAULT;
                fault_q <= 1'b1;
            end else begin
                state_q <= ST_RUN;
                fault_q <= 1'b0;
            end
        end else begin
            state_q <= state_q;
            fault_q <= fault_q;
        end
    end

    assign run_s       = (state_q == ST_RUN);
    assign instr_fault = fault_q;
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign run_s       = 1'b1;
    assign instr_fault = 1'b0;
`endif

    assign redir_pc_s = {redirect_pc[31:2], 2'b00};
    assign pop_s      = instr_valid & instr_ready;

    // A head popped this cycle frees its slot before any new response can land, so it counts as credit.
    assign credit_s = {1'b0, outstanding_q} - {1'b0, drop_cnt_q} + {1'b0, count_q}
                    - {{CW{1'b0}}, pop_s};

    assign imem_req_valid = ~reset & run_s & ~redirect_valid
                          & (outstanding_q < DEPTH_C) & (credit_s < DEPTH_W);
    assign imem_addr      = fetch_pc_q;
    assign req_fire_s     = imem_req_valid & imem_req_ready;
    assign push_s         = imem_rsp_valid & ~redirect_valid & (drop_cnt_q == {CW{1'b0}});

    assign instr_valid = (count_q != {CW{1'b0}});
    assign instr       = q_data_q[head_q];
    assign instr_pc    = q_pc_q[head_q];

    // Next-state for fetch PC, in-flight bookkeeping and queue pointers.
    always_comb begin
        tag_wr_d      = req_fire_s ? ptr_inc(tag_wr_q) : tag_wr_q;
        tag_rd_d      = imem_rsp_valid ? ptr_inc(tag_rd_q) : tag_rd_q;
        outstanding_d = outstanding_q + CW'(req_fire_s) - CW'(imem_rsp_valid);
        fetch_pc_d    = fetch_pc_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        if (redirect_valid) begin
            fetch_pc_d = redir_pc_s;
            drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
            count_d    = {CW{1'b0}};
            head_d     = {PW{1'b0}};
            tail_d     = {PW{1'b0}};
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (imem_rsp_valid && (drop_cnt_q != {CW{1'b0}})) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
            head_d  = pop_s ? ptr_inc(head_q) : head_q;
            tail_d  = push_s ? ptr_inc(tail_q) : tail_q;
        end
    end

    // Tag queue remembers each accepted PC so the matching response carries it into the instruction queue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= {CW{1'b0}};
            drop_cnt_q    <= {CW{1'b0}};
            count_q       <= {CW{1'b0}};
            head_q        <= {PW{1'b0}};
            tail_q        <= {PW{1'b0}};
            tag_rd_q      <= {PW{1'b0}};
            tag_wr_q      <= {PW{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_pc_q[i]   <= 32'h0;
                q_data_q[i] <= 32'h0;
                tag_pc_q[i] <= 32'h0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            if (push_s) begin
                q_pc_q[tail_q]   <= tag_pc_q[tag_rd_q];
                q_data_q[tail_q] <= imem_rsp_data;
            end
            if (req_fire_s) begin
                tag_pc_q[tag_wr_q] <= fetch_pc_q;
            end
        end
    end
endmodule
